door_sequencer: RTL

Tick-driven sequencer for the automatic sliding door motor. It synchronises the presence (`sense`) and obstacle (`obs`) sensors and tracks door position by counting motion ticks. It drives the 2-bit motor command, handles obstacle reversals with a retry limit, and raises the alarm. It sits between the raw sensor pins and the motor driver, replacing free-running slow-clock FSMs with a single-clock design that uses a tick enable.

---
 rtl/door_sequencer_if.sv | 25 ++
 rtl/door_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/door_sequencer_if.sv
// Sensor inputs and motor/status outputs of the door sequencer.
// door_pos width follows the travel length so both ends agree on it.
interface door_sequencer_if #(
   parameter int TRAVEL_TICKS = 30
);
   localparam int POS_W = $clog2(TRAVEL_TICKS + 1);

   logic             sense;
   logic             obs;
   logic [1:0]       motor;
   logic             alarm;
   logic [2:0]       state;
   logic [POS_W-1:0] door_pos;
   logic             tick;

   modport master (
      output sense, obs,
      input  motor, alarm, state, door_pos, tick
   );

   modport slave (
      input  sense, obs,
      output motor, alarm, state, door_pos, tick
   );
endinterface

// File: rtl/door_sequencer.sv
// Sliding-door motor sequencer: synchronised sensors, tick-enabled FSM, position count.
// Obstacles act on any clk (3 edges from pin to motor); tick events act on the tick-ending edge.
module door_sequencer #(
   parameter int TICK_DIV          = 5_000_000,
   parameter int TRAVEL_TICKS      = 30,
   parameter int HOLD_TICKS        = 50,
   parameter int MAX_REVERSALS     = 3,
   parameter int ALARM_CLEAR_TICKS = 20
) (
   input  logic             clk,
   input  logic             rst,
   door_sequencer_if.slave  bus
);
   localparam int PW    = $clog2(TICK_DIV);
   localparam int POS_W = $clog2(TRAVEL_TICKS + 1);
   localparam int HW    = $clog2(HOLD_TICKS + 1);
   localparam int RW    = $clog2(MAX_REVERSALS + 1);
   localparam int CW    = $clog2(ALARM_CLEAR_TICKS + 1);

   localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [POS_W-1:0] POS_FULL   = POS_W'(TRAVEL_TICKS);
   localparam logic [POS_W-1:0] POS_NEAR   = POS_W'(TRAVEL_TICKS - 1);
   localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);
   localparam logic [HW-1:0]    HOLD_LOAD  = HW'(HOLD_TICKS);
   localparam logic [HW-1:0]    HOLD_ONE   = HW'(1);
   localparam logic [RW-1:0]    REV_MAX    = RW'(MAX_REVERSALS);
   localparam logic [CW-1:0]    CLR_DONE   = CW'(ALARM_CLEAR_TICKS);

   typedef enum logic [2:0] {
      ST_CLOSED  = 3'b000,
      ST_OPENING = 3'b001,
      ST_OPEN    = 3'b010,
      ST_CLOSING = 3'b011,
      ST_ALARM   = 3'b100
   } state_e;

   state_e           state_q, state_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [RW-1:0]    rev_q, rev_d;
   logic [CW-1:0]    clr_q, clr_d;
   logic [PW-1:0]    presc_q;
   logic [1:0]       motor_q, motor_d;
   logic             alarm_q, alarm_d;
   logic             sense_m_q, sense_s_q, obs_m_q, obs_s_q;
   logic             tick;
   logic [RW-1:0]    rev_inc;
   logic [CW-1:0]    clr_inc;

   assign tick    = (presc_q == PRESC_LAST);
   assign rev_inc = rev_q + RW'(1);
   assign clr_inc = clr_q + CW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sense_m_q <= 1'b0;
         sense_s_q <= 1'b0;
         obs_m_q   <= 1'b0;
         obs_s_q   <= 1'b0;
         presc_q   <= '0;
         state_q   <= ST_CLOSED;
         pos_q     <= '0;
         hold_q    <= '0;
         rev_q     <= '0;
         clr_q     <= '0;
         motor_q   <= 2'b00;
         alarm_q   <= 1'b0;
      end else begin
         sense_m_q <= bus.sense;
         sense_s_q <= sense_m_q;
         obs_m_q   <= bus.obs;
         obs_s_q   <= obs_m_q;
         presc_q   <= tick ? '0 : presc_q + PW'(1);
         state_q   <= state_d;
         pos_q     <= pos_d;
         hold_q    <= hold_d;
         rev_q     <= rev_d;
         clr_q     <= clr_d;
         motor_q   <= motor_d;
         alarm_q   <= alarm_d;
      end
   end

   // Obstacle branches come first in each state and never touch pos_d.
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      hold_d  = hold_q;
      rev_d   = rev_q;
      clr_d   = clr_q;
      case (state_q)
         ST_CLOSED: begin
            rev_d = '0;
            if (tick && sense_s_q) state_d = ST_OPENING;
         end
         ST_OPENING: begin
            if (obs_s_q) begin
               state_d = ST_ALARM;
               clr_d   = '0;
            end else if (tick) begin
               if (pos_q >= POS_NEAR) begin
                  pos_d   = POS_FULL;
                  state_d = ST_OPEN;
                  hold_d  = HOLD_LOAD;
               end else begin
                  pos_d = pos_q + POS_ONE;
               end
            end
         end
         ST_OPEN: begin
            if (tick) begin
               if (sense_s_q || obs_s_q) begin
                  hold_d = HOLD_LOAD;
               end else if (hold_q <= HOLD_ONE) begin
                  hold_d  = '0;
                  state_d = ST_CLOSING;
               end else begin
                  hold_d = hold_q - HOLD_ONE;
               end
            end
         end
         ST_CLOSING: begin
            if (obs_s_q) begin
               rev_d   = rev_inc;
               state_d = (rev_inc == REV_MAX) ? ST_ALARM : ST_OPENING;
               clr_d   = '0;
            end else if (tick) begin
               if (sense_s_q) begin
                  state_d = ST_OPENING;
               end else if (pos_q <= POS_ONE) begin
                  pos_d   = '0;
                  state_d = ST_CLOSED;
                  rev_d   = '0;
               end else begin
                  pos_d = pos_q - POS_ONE;
               end
            end
         end
         ST_ALARM: begin
            if (obs_s_q) begin
               clr_d = '0;
            end else if (tick) begin
               if (clr_inc == CLR_DONE) begin
                  state_d = ST_OPENING;
                  clr_d   = '0;
                  rev_d   = '0;
               end else begin
                  clr_d = clr_inc;
               end
            end
         end
         default: state_d = ST_CLOSED;
      endcase
   end

   always_comb begin
      motor_d = 2'b00;
      alarm_d = 1'b0;
      case (state_d)
         ST_OPENING: motor_d = 2'b01;
         ST_CLOSING: motor_d = 2'b10;
         ST_ALARM:   alarm_d = 1'b1;
         default:    motor_d = 2'b00;
      endcase
   end

   assign bus.motor    = motor_q;
   assign bus.alarm    = alarm_q;
   assign bus.state    = state_q;
   assign bus.door_pos = pos_q;
   assign bus.tick     = tick;
endmodule
